trng_conditioner: RTL and testbench

Parametrised entropy post-processor between the raw ring-oscillator sampler and the tile output mux of the TRNG. Accepts one raw bit per qualified cycle, runs a repetition-count health test, optionally removes bias with a von Neumann corrector, and packs bits into WIDTH-bit words. Words are buffered in a DEPTH-entry show-ahead FIFO with a valid/read handshake.

---
 rtl/trng_conditioner.sv | 171 +++++++++++++++++
 tb/tb_trng_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_conditioner.sv
// Entropy post-processor: repetition-count health test, optional von Neumann
// debias, WIDTH-bit word assembly and a show-ahead output FIFO.
module trng_conditioner #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int RCT_CUTOFF = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       raw_bit,
    input  logic                       raw_valid,
    input  logic                       mode,
    input  logic                       rd_en,
    input  logic                       clr_fail,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       health_fail,
    output logic                       overrun
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = $clog2(RCT_CUTOFF+1);
    localparam int BW = $clog2(WIDTH);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [RW-1:0] CUTOFF     = RW'(RCT_CUTOFF);
    localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH-1);

    logic             prev_bit_reg;
    logic [RW-1:0]    run_len_reg, run_len_next;
    logic             health_fail_reg;
    logic             mode_reg;
    logic             phase_reg, phase_next;
    logic             first_reg, first_next;
    logic [WIDTH-2:0] shift_reg;
    logic [BW-1:0]    bit_cnt_reg;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             overrun_reg;

    logic             accepted, trip, blocked, mode_change, phase_eff;
    logic             fwd_valid, fwd_bit, word_done;
    logic [WIDTH-1:0] word;
    logic             pop, full, push_ok, drop;

    assign accepted = raw_valid & ~clr_fail;

    // Run length counts identical accepted bits; 0 means no reference bit yet.
    always_comb begin
        run_len_next = run_len_reg;
        if (clr_fail) begin
            run_len_next = '0;
        end else if (accepted) begin
            if (run_len_reg != '0 && raw_bit == prev_bit_reg)
                run_len_next = (run_len_reg == CUTOFF) ? CUTOFF : run_len_reg + RW'(1);
            else
                run_len_next = RW'(1);
        end
    end

    assign trip        = accepted && (run_len_next == CUTOFF);
    assign blocked     = health_fail_reg | trip;
    assign mode_change = (mode != mode_reg);
    assign phase_eff   = phase_reg & ~mode_change;

    always_comb begin
        phase_next = phase_eff;
        first_next = first_reg;
        fwd_valid  = 1'b0;
        fwd_bit    = raw_bit;
        if (blocked) begin
            phase_next = 1'b0;
        end else if (accepted) begin
            if (mode) begin
                if (!phase_eff) begin
                    first_next = raw_bit;
                    phase_next = 1'b1;
                end else begin
                    phase_next = 1'b0;
                    if (raw_bit != first_reg) begin
                        fwd_valid = 1'b1;
                        fwd_bit   = first_reg;
                    end
                end
            end else begin
                fwd_valid = 1'b1;
            end
        end
    end

    assign word      = {shift_reg, fwd_bit};
    assign word_done = fwd_valid && (bit_cnt_reg == LAST_BIT);

    assign pop     = rd_en && (count_reg != '0);
    assign full    = (count_reg == FULL_COUNT);
    assign push_ok = word_done && (!full || pop);
    assign drop    = word_done && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_bit_reg    <= 1'b0;
            run_len_reg     <= '0;
            health_fail_reg <= 1'b0;
            mode_reg        <= 1'b0;
            phase_reg       <= 1'b0;
            first_reg       <= 1'b0;
        end else begin
            if (accepted)
                prev_bit_reg <= raw_bit;
            run_len_reg <= run_len_next;
            if (clr_fail)
                health_fail_reg <= 1'b0;
            else if (trip)
                health_fail_reg <= 1'b1;
            mode_reg  <= mode;
            phase_reg <= phase_next;
            first_reg <= first_next;
        end
    end

    // Partial word is dropped on a trip and held empty while failed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (blocked) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (fwd_valid) begin
            shift_reg   <= word[WIDTH-2:0];
            bit_cnt_reg <= word_done ? '0 : bit_cnt_reg + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            if (push_ok && !pop)
                count_reg <= count_reg + CW'(1);
            else if (pop && !push_ok)
                count_reg <= count_reg - CW'(1);
            if (drop)
                overrun_reg <= 1'b1;
        end
    end

    // Head word is read combinationally so it is visible the cycle after the push.
    assign rd_valid    = (count_reg != '0);
    assign rd_data     = rd_valid ? mem[rd_ptr_reg] : '0;
    assign fifo_count  = count_reg;
    assign health_fail = health_fail_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: vector table plus hand sequences for
// mode toggling, health test, FIFO full/overrun and asynchronous reset.
module tb_trng_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_bit;
    logic       raw_valid;
    logic       mode;
    logic       rd_en;
    logic       clr_fail;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       health_fail;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    trng_conditioner #(.WIDTH(8), .DEPTH(4), .RCT_CUTOFF(16)) dut (
        .clk(clk), .rst(rst), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .mode(mode), .rd_en(rd_en), .clr_fail(clr_fail), .rd_data(rd_data),
        .rd_valid(rd_valid), .fifo_count(fifo_count),
        .health_fail(health_fail), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        vn;
        int          n;
        logic [31:0] bits;
        logic [7:0]  word;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        raw_valid = 1'b1;
        raw_bit   = b;
        tick();
        raw_valid = 1'b0;
        raw_bit   = 1'b0;
    endtask

    task automatic send_bits(input int n, input logic [31:0] bits);
        for (int i = n - 1; i >= 0; i--)
            send_bit(bits[i]);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_fail = 1'b1;
        tick();
        clr_fail = 1'b0;
    endtask

    task automatic set_mode(input logic m);
        mode = m;
        tick();
    endtask

    task automatic read_expect(input string name, input logic [7:0] exp);
        check({name, " valid"}, {31'd0, rd_valid}, 32'd1);
        check({name, " data"}, {24'd0, rd_data}, {24'd0, exp});
        pop_one();
    endtask

    task automatic check_empty(input string name);
        check({name, " empty valid"}, {31'd0, rd_valid}, 32'd0);
        check({name, " empty data"}, {24'd0, rd_data}, 32'd0);
        check({name, " empty count"}, {29'd0, fifo_count}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{"byp_b3", 1'b0, 8,  32'h0000_00B3, 8'hB3};
        vecs[1] = '{"byp_5a", 1'b0, 8,  32'h0000_005A, 8'h5A};
        vecs[2] = '{"vn_f0",  1'b1, 22, 32'h0022_E975, 8'hF0};
        vecs[3] = '{"vn_55",  1'b1, 16, 32'h0000_6666, 8'h55};
        vecs[4] = '{"byp_00", 1'b0, 8,  32'h0000_0000, 8'h00};

        rst = 1'b1; raw_bit = 1'b0; raw_valid = 1'b0; mode = 1'b0;
        rd_en = 1'b0; clr_fail = 1'b0;
        #12;
        check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset rd_data", {24'd0, rd_data}, 32'd0);
        check("reset count", {29'd0, fifo_count}, 32'd0);
        check("reset health_fail", {31'd0, health_fail}, 32'd0);
        check("reset overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            set_mode(vecs[v].vn);
            send_bits(vecs[v].n, vecs[v].bits);
            check({vecs[v].name, " count"}, {29'd0, fifo_count}, 32'd1);
            read_expect(vecs[v].name, vecs[v].word);
            check_empty(vecs[v].name);
        end

        // Pending first VN bit must be dropped when mode toggles.
        set_mode(1'b1);
        send_bit(1'b1);
        set_mode(1'b0);
        set_mode(1'b1);
        send_bits(16, 32'h0000_AA55);
        check("toggle count", {29'd0, fifo_count}, 32'd1);
        read_expect("toggle", 8'hF0);

        // Health test trip: 16 ones.
        set_mode(1'b0);
        pulse_clr();
        send_bits(15, 32'h0000_7FFF);
        check("rct 15 ones health", {31'd0, health_fail}, 32'd0);
        send_bit(1'b1);
        check("rct trip health", {31'd0, health_fail}, 32'd1);
        check("rct trip count", {29'd0, fifo_count}, 32'd1);
        send_bits(8, 32'h0000_005A);
        check("rct failed count", {29'd0, fifo_count}, 32'd1);
        read_expect("rct word", 8'hFF);
        check("rct failed empty", {31'd0, rd_valid}, 32'd0);
        pulse_clr();
        check("rct cleared", {31'd0, health_fail}, 32'd0);
        send_bits(8, 32'h0000_003C);
        check("rct after clr count", {29'd0, fifo_count}, 32'd1);
        read_expect("rct after clr", 8'h3C);

        // 15 ones then a zero stays healthy.
        pulse_clr();
        send_bits(16, 32'h0000_FFFE);
        check("rct15 health", {31'd0, health_fail}, 32'd0);
        check("rct15 count", {29'd0, fifo_count}, 32'd2);
        read_expect("rct15 w0", 8'hFF);
        read_expect("rct15 w1", 8'hFE);

        // Full FIFO with a pop on the completing edge.
        send_bits(8, 32'h0000_00A1);
        send_bits(8, 32'h0000_00B2);
        send_bits(8, 32'h0000_00C3);
        send_bits(8, 32'h0000_00D4);
        check("full count", {29'd0, fifo_count}, 32'd4);
        send_bits(7, 32'h0000_0072);
        check("full head", {24'd0, rd_data}, 32'h0000_00A1);
        rd_en = 1'b1;
        send_bit(1'b1);
        rd_en = 1'b0;
        check("pushpop count", {29'd0, fifo_count}, 32'd4);
        check("pushpop overrun", {31'd0, overrun}, 32'd0);
        read_expect("pushpop w1", 8'hB2);
        read_expect("pushpop w2", 8'hC3);
        read_expect("pushpop w3", 8'hD4);
        read_expect("pushpop w4", 8'hE5);
        check_empty("pushpop");

        // Overrun: five words, no reads.
        send_bits(8, 32'h0000_0011);
        send_bits(8, 32'h0000_0022);
        send_bits(8, 32'h0000_0033);
        send_bits(8, 32'h0000_0044);
        check("ovr pre count", {29'd0, fifo_count}, 32'd4);
        check("ovr pre flag", {31'd0, overrun}, 32'd0);
        send_bits(8, 32'h0000_0055);
        check("ovr count", {29'd0, fifo_count}, 32'd4);
        check("ovr flag", {31'd0, overrun}, 32'd1);
        read_expect("ovr w1", 8'h11);
        read_expect("ovr w2", 8'h22);
        read_expect("ovr w3", 8'h33);
        read_expect("ovr w4", 8'h44);
        check_empty("ovr");

        // Asynchronous reset mid-word with two words stored.
        send_bits(8, 32'h0000_009A);
        send_bits(8, 32'h0000_006B);
        send_bits(5, 32'h0000_0019);
        check("prerst count", {29'd0, fifo_count}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rst rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst rd_data", {24'd0, rd_data}, 32'd0);
        check("rst count", {29'd0, fifo_count}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        check("rst health_fail", {31'd0, health_fail}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_bits(8, 32'h0000_002D);
        check("postrst count", {29'd0, fifo_count}, 32'd1);
        read_expect("postrst", 8'h2D);
        check_empty("postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
